// File: rtl/ca_row_writer.sv
// ca_row_writer
// Last stage of the 1-D cellular-automaton engine. Takes one finished
// generation per valid/ready handshake and writes it, one pixel per clock,
// into the 1-bit VGA frame buffer (M4K port A) at address {x,y}. Each
// accepted generation goes on the next screen line. The whole buffer is
// cleared after reset or on request, and a one-cycle pulse marks the end
// of a frame.
//
// Ports
//   iCLK         clock (VGA control clock domain)
//   iRST         asynchronous reset, active high
//   iClear       one-cycle request: drop current work, clear buffer, restart at line 0
//   iRow         generation to draw, bit x -> pixel x
//   iRow_valid   iRow is valid
//   oRow_ready   a row can be accepted this cycle (combinational)
//   oAddr        buffer address {x,y} (registered)
//   oData        buffer write data (registered)
//   oWe          buffer write enable (registered)
//   oRow_count   rows drawn in the current frame, 0..NUM_ROWS
//   oFrame_done  one-cycle pulse after the last line of the frame is written
//   oBusy        writer is not idle (combinational)
//
// state  | meaning
// CLEAR  | zero-fill the buffer, one pixel per cycle, x inner / y outer
// IDLE   | waiting for a row; oRow_ready high unless iClear is asserted
// WRITE  | serialising the shadowed row onto line y
// FULL   | frame complete, holds the picture until iClear

module ca_row_writer #(
  parameter int ROW_WIDTH = 640,
  parameter int NUM_ROWS  = 480,
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 9
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iClear,
  input  logic [ROW_WIDTH-1:0]     iRow,
  input  logic                     iRow_valid,
  output logic                     oRow_ready,
  output logic [X_BITS+Y_BITS-1:0] oAddr,
  output logic                     oData,
  output logic                     oWe,
  output logic [Y_BITS-1:0]        oRow_count,
  output logic                     oFrame_done,
  output logic                     oBusy
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(ROW_WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(NUM_ROWS - 1);

  state_t               state;
  state_t               state_nxt;

  // x,y always name the pixel currently presented on oAddr while writing.
  logic [X_BITS-1:0]    x;
  logic [Y_BITS-1:0]    y;
  logic [X_BITS-1:0]    x_inc;
  logic [Y_BITS-1:0]    y_inc;
  logic [ROW_WIDTH-1:0] shadow;
  logic                 x_last;
  logic                 y_last;

  // One-hot-ish action strobes decoded from the FSM for the datapath.
  logic                 restart;
  logic                 accept;
  logic                 clr_first;
  logic                 clr_step;
  logic                 clr_done;
  logic                 wr_step;
  logic                 row_done;

  assign x_inc  = x + 1'b1;
  assign y_inc  = y + 1'b1;
  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);
  assign oBusy  = (state != ST_IDLE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    oRow_ready = 1'b0;
    restart    = 1'b0;
    accept     = 1'b0;
    clr_first  = 1'b0;
    clr_step   = 1'b0;
    clr_done   = 1'b0;
    wr_step    = 1'b0;
    row_done   = 1'b0;

    case (state)
      ST_CLEAR: begin
        // After reset nothing is on the bus yet (oWe low), so the first
        // edge only presents {0,0}. A clear entered via iClear already
        // presented {0,0} on the entry edge.
        if (!oWe) begin
          clr_first = 1'b1;
        end else if (x_last && y_last) begin
          clr_done  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          clr_step = 1'b1;
        end
      end

      ST_IDLE: begin
        oRow_ready = ~iClear;
        if (iClear) begin
          restart   = 1'b1;
          state_nxt = ST_CLEAR;
        end else if (iRow_valid) begin
          accept    = 1'b1;
          state_nxt = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (iClear) begin
          restart   = 1'b1;
          state_nxt = ST_CLEAR;
        end else if (x_last) begin
          row_done  = 1'b1;
          state_nxt = y_last ? ST_FULL : ST_IDLE;
        end else begin
          wr_step = 1'b1;
        end
      end

      ST_FULL: begin
        if (iClear) begin
          restart   = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end

      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x           <= '0;
      y           <= '0;
      shadow      <= '0;
      oAddr       <= '0;
      oData       <= 1'b0;
      oWe         <= 1'b0;
      oRow_count  <= '0;
      oFrame_done <= 1'b0;
    end else begin
      oFrame_done <= 1'b0;

      if (restart || clr_first) begin
        // Abandon whatever was in flight and put the first clear write
        // on the bus straight away.
        x          <= '0;
        y          <= '0;
        oAddr      <= '0;
        oData      <= 1'b0;
        oWe        <= 1'b1;
        oRow_count <= '0;
      end else if (clr_step) begin
        if (x_last) begin
          x     <= '0;
          y     <= y_inc;
          oAddr <= {{X_BITS{1'b0}}, y_inc};
        end else begin
          x     <= x_inc;
          oAddr <= {x_inc, y};
        end
        oData <= 1'b0;
        oWe   <= 1'b1;
      end else if (clr_done) begin
        x          <= '0;
        y          <= '0;
        oWe        <= 1'b0;
        oRow_count <= '0;
      end else if (accept) begin
        // The shadow decouples the write-out from later changes on iRow.
        shadow <= iRow;
        x      <= '0;
        oAddr  <= {{X_BITS{1'b0}}, y};
        oData  <= iRow[0];
        oWe    <= 1'b1;
      end else if (wr_step) begin
        x     <= x_inc;
        oAddr <= {x_inc, y};
        oData <= shadow[x_inc];
        oWe   <= 1'b1;
      end else if (row_done) begin
        // y may reach NUM_ROWS here; that only happens on the way to FULL,
        // where it is never used as an address.
        x           <= '0;
        y           <= y_inc;
        oRow_count  <= oRow_count + 1'b1;
        oWe         <= 1'b0;
        oFrame_done <= y_last;
      end else begin
        oWe <= 1'b0;
      end
    end
  end

endmodule
